// File: rtl/shared_dev_arbiter_pkg.sv
// Shared definitions for the two-CPU peripheral window arbiter.
//   - Owner encoding as seen on the OWNER port and in the lock status byte.
//   - FSM state encoding. State values equal the owner codes, so OWNER is the
//     state register itself and also serves as the FSM debug view.
//   - Lock register data bit positions and the status byte layout.
package shared_dev_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P1   = 2'd1;
  localparam logic [1:0] OWN_P2   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN1 = 2'd1,
    ST_OWN2 = 2'd2
  } state_t;

  // Lock write: bit0 = 1 acquire, bit0 = 0 release/cancel.
  localparam int LOCK_ACQ_BIT  = 0;
  // Lock read: {5'b0, lost, owner[1:0]}.
  localparam int STAT_LOST_BIT = 2;

  function automatic logic [7:0] lock_status(input logic lost, input logic [1:0] owner);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_LOST_BIT] = lost;
    s[1:0] = owner;
    return s;
  endfunction

endpackage

// File: rtl/arb_bus_port.sv
// One CPU-side port of the shared device arbiter.
//   - Decodes the CPU's write/read buses into lock hits and window hits.
//   - Holds this CPU's pending (acquire requested) and lost (timed out) bits.
//   - Registers a one-cycle read-return flag and drives the CPU's INBUS data,
//     which is 0 in every cycle without a returned read (OR-bus friendly).
// Ports:
//   clk, rst             clock, async active-high reset
//   out_addr/out_we      CPU write address / strobe
//   lock_bit             acquire bit of the CPU write data
//   in_addr/in_re        CPU read address / strobe
//   is_owner             this CPU currently owns the window (registered)
//   grant                this CPU is granted at the coming edge
//   set_lost             this CPU is force-released at the coming edge
//   owner                current owner code, captured by lock reads
//   dev_data             device read data (valid the cycle after the read)
//   lock_rel             release write to the lock register this cycle
//   pend_eff             pending including this cycle's acquire/release
//   access               owner access to the lock or window this cycle
//   fwd_wr/fwd_rd        owner window write/read to forward to the device
//   in_data              CPU read data
module arb_bus_port
  import shared_dev_arbiter_pkg::*;
#(
  parameter logic [7:0] LOCK_DEVADDR  = 8'h2C,
  parameter logic [7:0] WIN_BASE      = 8'h20,
  parameter int         WIN_SIZE_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] out_addr,
  input  logic       out_we,
  input  logic       lock_bit,
  input  logic [7:0] in_addr,
  input  logic       in_re,
  input  logic       is_owner,
  input  logic       grant,
  input  logic       set_lost,
  input  logic [1:0] owner,
  input  logic [7:0] dev_data,
  output logic       lock_rel,
  output logic       pend_eff,
  output logic       access,
  output logic       fwd_wr,
  output logic       fwd_rd,
  output logic [7:0] in_data
);

  localparam logic [7:0] WIN_MASK = 8'hFF << WIN_SIZE_LOG2;

  logic       lock_wr, lock_rd, win_wr, win_rd, lock_acq;
  logic       pending_q, lost_q, rd_win_q, rd_lock_q;
  logic [7:0] status_q;

  assign lock_wr = out_we && (out_addr == LOCK_DEVADDR);
  assign lock_rd = in_re && (in_addr == LOCK_DEVADDR);
  assign win_wr  = out_we && ((out_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
  assign win_rd  = in_re && ((in_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));

  // An acquire from the current owner only refreshes its timeout; it must
  // not leave a stale request behind once the owner later releases.
  assign lock_acq = lock_wr && lock_bit && !is_owner;
  assign lock_rel = lock_wr && !lock_bit;

  // Same-cycle view so an acquire can be granted on the very next edge.
  assign pend_eff = lock_acq || (pending_q && !lock_rel);

  assign access = is_owner && (lock_wr || lock_rd || win_wr || win_rd);
  assign fwd_wr = is_owner && win_wr;
  assign fwd_rd = is_owner && win_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      lost_q    <= 1'b0;
      rd_win_q  <= 1'b0;
      rd_lock_q <= 1'b0;
      status_q  <= 8'h00;
    end else begin
      pending_q <= grant ? 1'b0 : pend_eff;
      // A new force-release wins over a status read in the same cycle so
      // the event is never lost unseen.
      if (set_lost)     lost_q <= 1'b1;
      else if (lock_rd) lost_q <= 1'b0;
      // The return flag follows the issuing CPU, even if ownership moves.
      rd_win_q  <= fwd_rd;
      rd_lock_q <= lock_rd;
      if (lock_rd) status_q <= lock_status(lost_q, owner);
    end
  end

  always_comb begin
    in_data = 8'h00;
    if (rd_win_q)       in_data = dev_data;
    else if (rd_lock_q) in_data = status_q;
  end

endmodule

// File: rtl/shared_dev_arbiter.sv
// Shares one memory-mapped peripheral window between two processor buses.
// The processor bus cannot stall, so ownership is taken and released by
// software through a lock register decoded on both buses. Only the owner's
// window accesses reach the device; the other CPU's writes are dropped and
// its reads return 0. An idle owner is force-released after TIMEOUT_CYCLES.
// Ports:
//   clk, reset                       clock, async active-high reset
//   OUTBUS_ADDR/DATA/WE 1,2          CPU write buses
//   INBUS_ADDR/RE 1,2                CPU read requests
//   INBUS_DATA 1,2                   CPU read data, 0 when nothing returns
//   DEV_OUTBUS_ADDR/DATA/WE          forwarded owner writes
//   DEV_INBUS_ADDR/RE                forwarded owner reads
//   DEV_INBUS_DATA                   device read data, one cycle after RE
//   OWNER                            0 none, 1 proc1, 2 proc2 (FSM state)
module shared_dev_arbiter
  import shared_dev_arbiter_pkg::*;
#(
  parameter logic [7:0] LOCK_DEVADDR   = 8'h2C,
  parameter logic [7:0] WIN_BASE       = 8'h20,
  parameter int         WIN_SIZE_LOG2  = 3,
  parameter int         TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] OUTBUS_ADDR1,
  input  logic [7:0] OUTBUS_DATA1,
  input  logic       OUTBUS_WE1,
  input  logic [7:0] INBUS_ADDR1,
  input  logic       INBUS_RE1,
  output logic [7:0] INBUS_DATA1,
  input  logic [7:0] OUTBUS_ADDR2,
  input  logic [7:0] OUTBUS_DATA2,
  input  logic       OUTBUS_WE2,
  input  logic [7:0] INBUS_ADDR2,
  input  logic       INBUS_RE2,
  output logic [7:0] INBUS_DATA2,
  output logic [7:0] DEV_OUTBUS_ADDR,
  output logic [7:0] DEV_OUTBUS_DATA,
  output logic       DEV_OUTBUS_WE,
  output logic [7:0] DEV_INBUS_ADDR,
  output logic       DEV_INBUS_RE,
  input  logic [7:0] DEV_INBUS_DATA,
  output logic [1:0] OWNER
);

  localparam logic [7:0] WIN_MASK = 8'hFF << WIN_SIZE_LOG2;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYCLES - 1'b1;

  if ((WIN_BASE & ~WIN_MASK) != 8'h00) begin : g_bad_win_align
    $error("WIN_BASE is not aligned to the window size");
  end
  if ((LOCK_DEVADDR & WIN_MASK) == (WIN_BASE & WIN_MASK)) begin : g_bad_lock_alias
    $error("LOCK_DEVADDR falls inside the shared window");
  end

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 grant1, grant2, lost1, lost2, timeout, owner_access;
  logic                 rel1, rel2, pe1, pe2, acc1, acc2;
  logic                 fwr1, fwr2, frd1, frd2;

  assign OWNER = state_q;

  arb_bus_port #(
    .LOCK_DEVADDR (LOCK_DEVADDR),
    .WIN_BASE     (WIN_BASE),
    .WIN_SIZE_LOG2(WIN_SIZE_LOG2)
  ) u_port1 (
    .clk     (clk),
    .rst     (reset),
    .out_addr(OUTBUS_ADDR1),
    .out_we  (OUTBUS_WE1),
    .lock_bit(OUTBUS_DATA1[LOCK_ACQ_BIT]),
    .in_addr (INBUS_ADDR1),
    .in_re   (INBUS_RE1),
    .is_owner(state_q == ST_OWN1),
    .grant   (grant1),
    .set_lost(lost1),
    .owner   (OWNER),
    .dev_data(DEV_INBUS_DATA),
    .lock_rel(rel1),
    .pend_eff(pe1),
    .access  (acc1),
    .fwd_wr  (fwr1),
    .fwd_rd  (frd1),
    .in_data (INBUS_DATA1)
  );

  arb_bus_port #(
    .LOCK_DEVADDR (LOCK_DEVADDR),
    .WIN_BASE     (WIN_BASE),
    .WIN_SIZE_LOG2(WIN_SIZE_LOG2)
  ) u_port2 (
    .clk     (clk),
    .rst     (reset),
    .out_addr(OUTBUS_ADDR2),
    .out_we  (OUTBUS_WE2),
    .lock_bit(OUTBUS_DATA2[LOCK_ACQ_BIT]),
    .in_addr (INBUS_ADDR2),
    .in_re   (INBUS_RE2),
    .is_owner(state_q == ST_OWN2),
    .grant   (grant2),
    .set_lost(lost2),
    .owner   (OWNER),
    .dev_data(DEV_INBUS_DATA),
    .lock_rel(rel2),
    .pend_eff(pe2),
    .access  (acc2),
    .fwd_wr  (fwr2),
    .fwd_rd  (frd2),
    .in_data (INBUS_DATA2)
  );

  // acc1/acc2 are already gated by ownership, so this is the owner only.
  assign owner_access = acc1 || acc2;

  // Fires in the cycle the counter sits at its last value with no owner
  // activity; the release takes effect at the following edge.
  assign timeout = (TIMEOUT_CYCLES != '0) && (state_q != ST_IDLE) &&
                   !owner_access && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_P2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (grant1 || grant2 || owner_access) cnt_q <= '0;
      else if ((state_q != ST_IDLE) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant1  = 1'b0;
    grant2  = 1'b0;
    lost1   = 1'b0;
    lost2   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the CPU that was not granted last time wins.
        if (pe1 && (!pe2 || (last_q == OWN_P2))) grant1 = 1'b1;
        else if (pe2)                            grant2 = 1'b1;
      end
      ST_OWN1: begin
        if (rel1 || timeout) begin
          lost1 = timeout;
          if (pe2) grant2 = 1'b1;
          else     state_d = ST_IDLE;
        end
      end
      ST_OWN2: begin
        if (rel2 || timeout) begin
          lost2 = timeout;
          if (pe1) grant1 = 1'b1;
          else     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant1) begin
      state_d = ST_OWN1;
      last_d  = OWN_P1;
    end else if (grant2) begin
      state_d = ST_OWN2;
      last_d  = OWN_P2;
    end
  end

  // Zero-latency forwarding from the registered owner's bus only.
  always_comb begin
    DEV_OUTBUS_ADDR = 8'h00;
    DEV_OUTBUS_DATA = 8'h00;
    DEV_OUTBUS_WE   = 1'b0;
    DEV_INBUS_ADDR  = 8'h00;
    DEV_INBUS_RE    = 1'b0;
    if (fwr1) begin
      DEV_OUTBUS_ADDR = OUTBUS_ADDR1;
      DEV_OUTBUS_DATA = OUTBUS_DATA1;
      DEV_OUTBUS_WE   = 1'b1;
    end else if (fwr2) begin
      DEV_OUTBUS_ADDR = OUTBUS_ADDR2;
      DEV_OUTBUS_DATA = OUTBUS_DATA2;
      DEV_OUTBUS_WE   = 1'b1;
    end
    if (frd1) begin
      DEV_INBUS_ADDR = INBUS_ADDR1;
      DEV_INBUS_RE   = 1'b1;
    end else if (frd2) begin
      DEV_INBUS_ADDR = INBUS_ADDR2;
      DEV_INBUS_RE   = 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_dev_arbiter.sv
// Bench for shared_dev_arbiter: directed steps followed by random traffic,
// every cycle compared against a behavioural model of the lock protocol.
module tb_shared_dev_arbiter;

  localparam logic [7:0] LOCK  = 8'h2C;
  localparam logic [7:0] WBASE = 8'h20;
  localparam int         TO    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] o_addr [1:2];
  logic [7:0] o_data [1:2];
  logic       o_we   [1:2];
  logic [7:0] i_addr [1:2];
  logic       i_re   [1:2];
  logic [7:0] dev_data;

  logic [7:0] INBUS_DATA1, INBUS_DATA2;
  logic [7:0] DEV_OUTBUS_ADDR, DEV_OUTBUS_DATA, DEV_INBUS_ADDR;
  logic       DEV_OUTBUS_WE, DEV_INBUS_RE;
  logic [1:0] OWNER;

  shared_dev_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk            (clk),
    .reset          (reset),
    .OUTBUS_ADDR1   (o_addr[1]),
    .OUTBUS_DATA1   (o_data[1]),
    .OUTBUS_WE1     (o_we[1]),
    .INBUS_ADDR1    (i_addr[1]),
    .INBUS_RE1      (i_re[1]),
    .INBUS_DATA1    (INBUS_DATA1),
    .OUTBUS_ADDR2   (o_addr[2]),
    .OUTBUS_DATA2   (o_data[2]),
    .OUTBUS_WE2     (o_we[2]),
    .INBUS_ADDR2    (i_addr[2]),
    .INBUS_RE2      (i_re[2]),
    .INBUS_DATA2    (INBUS_DATA2),
    .DEV_OUTBUS_ADDR(DEV_OUTBUS_ADDR),
    .DEV_OUTBUS_DATA(DEV_OUTBUS_DATA),
    .DEV_OUTBUS_WE  (DEV_OUTBUS_WE),
    .DEV_INBUS_ADDR (DEV_INBUS_ADDR),
    .DEV_INBUS_RE   (DEV_INBUS_RE),
    .DEV_INBUS_DATA (dev_data),
    .OWNER          (OWNER)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_owner;          // 0 none, 1/2 cpu
  int         m_last;           // last granted cpu
  int         m_idle;           // owner idle cycles since grant/access
  bit         m_pend [1:2];
  bit         m_lost [1:2];
  int         m_ret  [1:2];     // 0 nothing, 1 device data, 2 status byte
  logic [7:0] m_stat [1:2];

  function automatic bit in_win(input logic [7:0] a);
    return (a >= WBASE) && (a <= WBASE + 8'd7);
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_idle  = 0;
    for (int n = 1; n <= 2; n++) begin
      m_pend[n] = 1'b0;
      m_lost[n] = 1'b0;
      m_ret[n]  = 0;
      m_stat[n] = 8'h00;
    end
  endtask

  // Applies one clock edge of protocol rules using the inputs now on the bus.
  task automatic model_step();
    bit acq [1:2];
    bit rel [1:2];
    bit lrd [1:2];
    bit acc [1:2];
    bit fired;
    int nxt;
    int other;
    for (int n = 1; n <= 2; n++) begin
      acq[n] = o_we[n] && (o_addr[n] == LOCK) && o_data[n][0];
      rel[n] = o_we[n] && (o_addr[n] == LOCK) && !o_data[n][0];
      lrd[n] = i_re[n] && (i_addr[n] == LOCK);
      acc[n] = (m_owner == n) &&
               ((o_we[n] && (o_addr[n] == LOCK || in_win(o_addr[n]))) ||
                (i_re[n] && (i_addr[n] == LOCK || in_win(i_addr[n]))));
    end
    for (int n = 1; n <= 2; n++) begin
      if (lrd[n]) begin
        m_ret[n]  = 2;
        m_stat[n] = 8'((m_lost[n] ? 4 : 0) + m_owner);
      end else if (i_re[n] && in_win(i_addr[n]) && m_owner == n) begin
        m_ret[n] = 1;
      end else begin
        m_ret[n] = 0;
      end
    end
    fired = (m_owner != 0) && !acc[m_owner] && (m_idle == TO - 1);
    for (int n = 1; n <= 2; n++) if (lrd[n]) m_lost[n] = 1'b0;
    if (fired) m_lost[m_owner] = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      if (n != m_owner) begin
        if (acq[n]) m_pend[n] = 1'b1;
        if (rel[n]) m_pend[n] = 1'b0;
      end
    end
    nxt = m_owner;
    if (m_owner == 0) begin
      if (m_pend[1] && m_pend[2]) nxt = (m_last == 1) ? 2 : 1;
      else if (m_pend[1])         nxt = 1;
      else if (m_pend[2])         nxt = 2;
    end else if (rel[m_owner] || fired) begin
      other = 3 - m_owner;
      nxt = m_pend[other] ? other : 0;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_pend[nxt] = 1'b0;
      m_last = nxt;
      m_idle = 0;
    end else if (m_owner != 0 && acc[m_owner]) begin
      m_idle = 0;
    end else if (m_owner != 0) begin
      m_idle++;
    end
    m_owner = nxt;
  endtask

  task automatic check_all();
    logic [7:0] ea, ed, ra, e_in;
    logic       ew, er;
    ea = 8'h00; ed = 8'h00; ew = 1'b0; ra = 8'h00; er = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      if (m_owner == n && o_we[n] && in_win(o_addr[n])) begin
        ea = o_addr[n]; ed = o_data[n]; ew = 1'b1;
      end
      if (m_owner == n && i_re[n] && in_win(i_addr[n])) begin
        ra = i_addr[n]; er = 1'b1;
      end
    end
    chk("owner",    32'(OWNER),           32'(m_owner));
    chk("dev_we",   32'(DEV_OUTBUS_WE),   32'(ew));
    chk("dev_addr", 32'(DEV_OUTBUS_ADDR), 32'(ea));
    chk("dev_data", 32'(DEV_OUTBUS_DATA), 32'(ed));
    chk("dev_re",   32'(DEV_INBUS_RE),    32'(er));
    chk("dev_radr", 32'(DEV_INBUS_ADDR),  32'(ra));
    for (int n = 1; n <= 2; n++) begin
      e_in = (m_ret[n] == 1) ? dev_data : (m_ret[n] == 2) ? m_stat[n] : 8'h00;
      if (n == 1) chk("inbus1", 32'(INBUS_DATA1), 32'(e_in));
      else        chk("inbus2", 32'(INBUS_DATA2), 32'(e_in));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    for (int n = 1; n <= 2; n++) begin
      o_addr[n] = 8'h00; o_data[n] = 8'h00; o_we[n] = 1'b0;
      i_addr[n] = 8'h00; i_re[n] = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic lock_wr(input int n, input logic [7:0] d);
    o_we[n] = 1'b1; o_addr[n] = LOCK; o_data[n] = d;
  endtask

  function automatic logic [7:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2) return LOCK;
    if (r == 9) return 8'($urandom);
    return WBASE + 8'($urandom_range(0, 7));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_in();
    dev_data = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    sample(); chk("rst_owner", 32'(OWNER), 32'd0); chk("rst_in1", 32'(INBUS_DATA1), 32'd0); tick();

    // acquire, then owner window write forwarded in the same cycle
    lock_wr(1, 8'h01); sample(); tick();
    idle_in(); o_we[1] = 1'b1; o_addr[1] = WBASE; o_data[1] = 8'h41;
    sample();
    chk("acq_owner", 32'(OWNER), 32'd1);
    chk("fwd_we",    32'(DEV_OUTBUS_WE), 32'd1);
    chk("fwd_addr",  32'(DEV_OUTBUS_ADDR), 32'h20);
    chk("fwd_data",  32'(DEV_OUTBUS_DATA), 32'h41);
    tick();

    // other CPU reads status
    idle_in(); i_re[2] = 1'b1; i_addr[2] = LOCK; sample(); tick();
    idle_in(); sample(); chk("p2_status", 32'(INBUS_DATA2), 32'h01); tick();

    // non-owner write/read dropped
    o_we[2] = 1'b1; o_addr[2] = 8'h21; o_data[2] = 8'h55;
    sample(); chk("nonown_we", 32'(DEV_OUTBUS_WE), 32'd0); tick();
    idle_in(); i_re[2] = 1'b1; i_addr[2] = 8'h21;
    sample(); chk("nonown_re", 32'(DEV_INBUS_RE), 32'd0); tick();
    idle_in(); sample(); chk("nonown_rd", 32'(INBUS_DATA2), 32'd0); tick();

    // owner read with one-cycle return
    i_re[1] = 1'b1; i_addr[1] = 8'h22;
    sample(); chk("own_re", 32'(DEV_INBUS_RE), 32'd1); chk("own_radr", 32'(DEV_INBUS_ADDR), 32'h22); tick();
    idle_in(); dev_data = 8'hA5;
    sample(); chk("own_rd1", 32'(INBUS_DATA1), 32'hA5); chk("own_rd2", 32'(INBUS_DATA2), 32'd0); tick();
    dev_data = 8'h00;

    // release, re-acquire, then idle into timeout
    lock_wr(1, 8'h00); sample(); tick();
    idle_in(); lock_wr(1, 8'h01); sample(); chk("rel_owner", 32'(OWNER), 32'd0); tick();
    idle_in();
    for (int i = 0; i < TO; i++) begin
      sample(); chk("to_hold", 32'(OWNER), 32'd1); tick();
    end
    i_re[1] = 1'b1; i_addr[1] = LOCK; sample(); chk("to_owner", 32'(OWNER), 32'd0); tick();
    idle_in(); sample(); chk("to_status", 32'(INBUS_DATA1), 32'h04); tick();
    i_re[1] = 1'b1; i_addr[1] = LOCK; sample(); tick();
    idle_in(); sample(); chk("to_status2", 32'(INBUS_DATA1), 32'h00); tick();

    // simultaneous acquire from reset, then direct hand-off
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    lock_wr(1, 8'h01); lock_wr(2, 8'h01); sample(); tick();
    idle_in(); lock_wr(1, 8'h00); sample(); chk("tie_owner", 32'(OWNER), 32'd1); tick();
    idle_in(); lock_wr(1, 8'h01); sample(); chk("handoff", 32'(OWNER), 32'd2); tick();

    // asynchronous reset in the middle of an owner write
    idle_in(); o_we[2] = 1'b1; o_addr[2] = 8'h23; o_data[2] = 8'h77;
    sample(); chk("own2_we", 32'(DEV_OUTBUS_WE), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_owner", 32'(OWNER), 32'd0);
    chk("arst_we",    32'(DEV_OUTBUS_WE), 32'd0);
    chk("arst_addr",  32'(DEV_OUTBUS_ADDR), 32'd0);
    chk("arst_data",  32'(DEV_OUTBUS_DATA), 32'd0);
    chk("arst_re",    32'(DEV_INBUS_RE), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    idle_in();
    sample(); tick();
    sample(); chk("rst_pend", 32'(OWNER), 32'd0); tick();

    // random traffic with periodic quiet stretches to reach the timeout
    for (int c = 0; c < 600; c++) begin
      if ((c % 60) >= 48) begin
        idle_in();
      end else begin
        for (int n = 1; n <= 2; n++) begin
          o_we[n]   = ($urandom_range(0, 2) == 0);
          o_addr[n] = rnd_addr();
          o_data[n] = 8'($urandom);
          i_re[n]   = ($urandom_range(0, 2) == 0);
          i_addr[n] = rnd_addr();
        end
      end
      dev_data = 8'($urandom);
      sample();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_dev_arbiter.md
Name: shared_dev_arbiter

Overview:
Shares one memory-mapped peripheral window (default: the rs232 port at 0x20-0x27) between two processor I/O buses, proc1 and proc2.
- The processor bus has no stall signal, so ownership is software-visible through a lock register.
- A CPU writes the lock register to acquire or release the window.
- Only the current owner's accesses are forwarded to the shared device. The other CPU's accesses are dropped and its reads return 0.
- An idle-owner timeout force-releases a hung owner.
- Sits in Top between both processorTop buses and the shared device.

Parameters:
- LOCK_DEVADDR, 8'h2C, lock/status register address, decoded on both buses.
- WIN_BASE, 8'h20, base address of the shared window; must be aligned to 2^WIN_SIZE_LOG2.
- WIN_SIZE_LOG2, 3, window size is 2^WIN_SIZE_LOG2 addresses.
- TIMEOUT_W, 16, width of the idle timeout counter.
- TIMEOUT_CYCLES, 16'd50000, owner idle cycles before forced release; 0 disables the timeout.

Ports:
- clk, in, 1, processor clock.
- reset, in, 1, asynchronous, active-high.
- OUTBUS_ADDR1 / OUTBUS_DATA1, in, 8 each, proc1 write bus.
- OUTBUS_WE1, in, 1, proc1 write strobe.
- INBUS_ADDR1, in, 8, proc1 read address.
- INBUS_RE1, in, 1, proc1 read strobe.
- INBUS_DATA1, out, 8, proc1 read data; 0 when not driving (OR-bus).
- OUTBUS_ADDR2, OUTBUS_DATA2, OUTBUS_WE2, INBUS_ADDR2, INBUS_RE2, INBUS_DATA2: same roles for proc2.
- DEV_OUTBUS_ADDR / DEV_OUTBUS_DATA, out, 8 each, forwarded write bus.
- DEV_OUTBUS_WE, out, 1, forwarded write strobe.
- DEV_INBUS_ADDR, out, 8, forwarded read address.
- DEV_INBUS_RE, out, 1, forwarded read strobe.
- DEV_INBUS_DATA, in, 8, device read data, valid one cycle after DEV_INBUS_RE.
- OWNER, out, 2, 0 = none, 1 = proc1, 2 = proc2.

Behaviour:
- Reset (async, active-high) results:
  - State IDLE; OWNER = 0.
  - pending[2:1], lost[2:1] and the read-valid flags cleared.
  - last_grant = 2, so proc1 wins the first tie.
  - Timeout counter cleared; all outputs 0.
  - Reset mid-transfer drops the access silently.
- FSM states IDLE, OWN1, OWN2; OWNER mirrors the state.
- Lock write: OUTBUS_WEn with OUTBUS_ADDRn == LOCK_DEVADDR.
  - Data bit0 = 1 is an acquire request and sets pending[n].
  - Data bit0 = 0 is a release/cancel and clears pending[n].
  - Other data bits are ignored.
- IDLE: any pending CPU is granted on the next clock.
  - Both pending: grant the CPU that is not last_grant.
  - On grant, last_grant updates and the grantee's pending bit clears.
- OWNn:
  - A release by n, or a timeout, leaves OWNn on the same clock.
  - If the other CPU is pending (including an acquire arriving in that same cycle), go directly to OWN(other); otherwise go to IDLE.
  - Acquire by the current owner: no state change, restarts the timeout.
- Timeout:
  - Counter clears on a grant and on any owner access (lock or window).
  - Otherwise it increments while in OWNn.
  - Reaching TIMEOUT_CYCLES-1 forces a release and sets lost[n].
  - Saturates, no wrap.
- Forwarding (combinational, zero latency, based on registered OWNER):
  - Owner OUTBUS within window: ADDR, DATA and WE pass to the DEV_OUTBUS signals.
  - Owner INBUS within window: ADDR and RE pass to the DEV_INBUS signals.
  - Otherwise all DEV_* outputs are 0.
  - Non-owner window writes are discarded; non-owner reads return 0.
  - A grant change affects forwarding starting the cycle after the clock edge.
- Read return (1-cycle latency, matching the other peripherals):
  - A registered flag records "owner read the window" and gates DEV_INBUS_DATA onto that CPU's INBUS_DATA in the next cycle.
  - Ownership lost in between: data still returns to the CPU that issued the read.
- Lock read: INBUS_DATAn returns {5'b0, lost[n], OWNER} one cycle after the read; lost[n] clears on that read.
- All INBUS_DATAn are 0 in cycles with no returned read.
- Window addresses never alias LOCK_DEVADDR; the parameter check fails elaboration if they overlap.

Decomposition:
- Shared package: owner encoding constants (OWN_NONE = 0, OWN_P1 = 1, OWN_P2 = 2), FSM state encodings, lock data bit positions.
- One natural sub-module, arb_bus_port, instantiated twice:
  - Per-CPU address decode (lock hit, window hit).
  - Pending/lost bits.
  - Read-return flag and INBUS_DATA mux.

Test Plan:
- proc1 writes 0x01 to 0x2C → OWNER = 1 next cycle. proc1 writes 0x41 to 0x20 → DEV_OUTBUS_WE = 1, ADDR = 0x20, DATA = 0x41 in the same cycle. proc2 read of 0x2C returns 0x01.
- proc1 and proc2 both write 0x01 to 0x2C in the same cycle from reset → OWNER = 1, pending[2] = 1. proc1 writes 0x00 → OWNER = 2 on the next clock, with no IDLE cycle.
- proc2 is non-owner and writes 0x55 to 0x21 → DEV_OUTBUS_WE stays 0. proc2 reads 0x21 → INBUS_DATA2 = 0.
- Owner proc1 reads 0x22 with device returning 0xA5 → INBUS_DATA1 = 0xA5 exactly one cycle after RE; INBUS_DATA2 stays 0.
- TIMEOUT_CYCLES = 8, proc1 owns and stays idle → OWNER = 0 after 8 cycles. proc1 read of 0x2C returns 0x04, and the next read returns 0x00.
- Reset asserted mid-ownership, asynchronous to clk → OWNER = 0 and all DEV_* = 0 immediately; pending bits clear.
